// File: rtl/note_playback_sequencer.sv
// note_playback_sequencer
//   Records decoded keyboard notes (note/octave) into a small buffer and replays
//   them in order. Each note sounds for NOTE_TICKS cycles, then GAP_TICKS cycles
//   of silence follow. Supports clear, stop and looped replay. The out_* outputs
//   drive the note-to-frequency lookup while out_active is high.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   rec_valid/note/octave   append one note to the buffer (IDLE, not full)
//   clear                   empty the buffer and abort playback
//   play_start / play_stop  begin playback at index 0 / abort playback
//   loop_en                 restart at index 0 after the last note
//   out_note/out_octave     note currently (or last) played
//   out_active              high while a note is sounding
//   busy                    playback in progress
//   note_count, full        buffer fill level
//   play_index              buffer index being played
//   done                    one-cycle pulse when non-looped playback ends
//
// state     | meaning
// IDLE      | not playing; recording allowed
// PLAY_NOTE | note at play_index is sounding, ticks counts its duration
// PLAY_GAP  | silent gap after a note, ticks counts the gap
module note_playback_sequencer #(
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int NOTE_TICKS = 25_000_000,
   parameter int GAP_TICKS  = 2_500_000,
   parameter int CNT_W      = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rec_valid,
   input  logic [3:0]        rec_note,
   input  logic [1:0]        rec_octave,
   input  logic              clear,
   input  logic              play_start,
   input  logic              play_stop,
   input  logic              loop_en,
   output logic [3:0]        out_note,
   output logic [1:0]        out_octave,
   output logic              out_active,
   output logic              busy,
   output logic [ADDR_W:0]   note_count,
   output logic [ADDR_W-1:0] play_index,
   output logic              full,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, PLAY_NOTE, PLAY_GAP} state_t;

   localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    ticks_q, ticks_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W-1:0]   index_q, index_d;
   logic [3:0]          note_q, note_d;
   logic [1:0]          oct_q, oct_d;
   logic                done_q, done_d;
   logic [5:0]          mem_q [DEPTH];

   logic                wr_en;
   logic                advance;
   logic                last_note;
   logic                full_c;
   logic [ADDR_W-1:0]   next_index;

   assign full_c     = (count_q == DEPTH_C);
   assign next_index = index_q + ADDR_W'(1);
   // index never exceeds count-1 while playing, so this marks the final entry
   assign last_note  = (({1'b0, index_q} + (ADDR_W + 1)'(1)) >= count_q);

   always_comb begin
      state_d = state_q;
      ticks_d = ticks_q;
      count_d = count_q;
      index_d = index_q;
      note_d  = note_q;
      oct_d   = oct_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      advance = 1'b0;

      if (clear) begin
         state_d = IDLE;
         count_d = '0;
         index_d = '0;
         ticks_d = '0;
      end else if (play_stop && (state_q != IDLE)) begin
         state_d = IDLE;
         index_d = '0;
         ticks_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // start decision uses the pre-write count; a same-edge record
               // still lands and becomes the last entry played
               if (play_start && (count_q != '0)) begin
                  state_d         = PLAY_NOTE;
                  index_d         = '0;
                  ticks_d         = '0;
                  {note_d, oct_d} = mem_q[0];
               end
               if (rec_valid && !full_c) begin
                  wr_en   = 1'b1;
                  count_d = count_q + (ADDR_W + 1)'(1);
               end
            end
            PLAY_NOTE: begin
               if (ticks_q == NOTE_LAST) begin
                  ticks_d = '0;
                  if (GAP_TICKS > 0) state_d = PLAY_GAP;
                  else               advance = 1'b1;
               end else begin
                  ticks_d = ticks_q + CNT_W'(1);
               end
            end
            PLAY_GAP: begin
               if (ticks_q == GAP_LAST) begin
                  ticks_d = '0;
                  advance = 1'b1;
               end else begin
                  ticks_d = ticks_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase

         if (advance) begin
            if (!last_note) begin
               state_d         = PLAY_NOTE;
               index_d         = next_index;
               {note_d, oct_d} = mem_q[next_index];
            end else if (loop_en) begin
               state_d         = PLAY_NOTE;
               index_d         = '0;
               {note_d, oct_d} = mem_q[0];
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ticks_q <= '0;
         count_q <= '0;
         index_q <= '0;
         note_q  <= '0;
         oct_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ticks_q <= ticks_d;
         count_q <= count_d;
         index_q <= index_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         done_q  <= done_d;
      end
   end

   // buffer contents need no reset; note_count qualifies what is valid
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= {rec_note, rec_octave};
   end

   assign out_note   = note_q;
   assign out_octave = oct_q;
   assign out_active = (state_q == PLAY_NOTE);
   assign busy       = (state_q != IDLE);
   assign note_count = count_q;
   assign play_index = index_q;
   assign full       = full_c;
   assign done       = done_q;

endmodule

// File: tb/tb_note_playback_sequencer.sv
module tb_note_playback_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       rec_valid, clear, play_start, play_stop, loop_en;
   logic [3:0] rec_note;
   logic [1:0] rec_octave;

   logic [3:0] out_note,   out_note0;
   logic [1:0] out_octave, out_octave0;
   logic       out_active, out_active0, busy, busy0, full, full0, done, done0;
   logic [2:0] note_count, note_count0;
   logic [1:0] play_index, play_index0;

   always #5 clk = ~clk;

   note_playback_sequencer #(.DEPTH(4), .ADDR_W(2), .NOTE_TICKS(4), .GAP_TICKS(2), .CNT_W(4)) dut (
      .clk(clk), .reset(rst), .rec_valid(rec_valid), .rec_note(rec_note), .rec_octave(rec_octave),
      .clear(clear), .play_start(play_start), .play_stop(play_stop), .loop_en(loop_en),
      .out_note(out_note), .out_octave(out_octave), .out_active(out_active), .busy(busy),
      .note_count(note_count), .play_index(play_index), .full(full), .done(done));

   note_playback_sequencer #(.DEPTH(4), .ADDR_W(2), .NOTE_TICKS(4), .GAP_TICKS(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(rst), .rec_valid(rec_valid), .rec_note(rec_note), .rec_octave(rec_octave),
      .clear(clear), .play_start(play_start), .play_stop(play_stop), .loop_en(loop_en),
      .out_note(out_note0), .out_octave(out_octave0), .out_active(out_active0), .busy(busy0),
      .note_count(note_count0), .play_index(play_index0), .full(full0), .done(done0));

   typedef struct {
      logic [3:0] note;
      logic [1:0] oct;
      logic [1:0] idx;
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] model_mem [4];
   int         model_cnt = 0;
   int         n_assert  = 0;
   int         n_fail    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic rec(input logic [3:0] n, input logic [1:0] o);
      rec_note = n; rec_octave = o; rec_valid = 1'b1;
      if (model_cnt < 4) begin
         model_mem[model_cnt] = {n, o};
         model_cnt++;
      end
      @(negedge clk);
      rec_valid = 1'b0;
   endtask

   task automatic push_play(input int passes);
      exp_t e;
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < model_cnt; i++) begin
            e.note = model_mem[i][5:2]; e.oct = model_mem[i][1:0]; e.idx = 2'(i);
            exp_q.push_back(e);
         end
   endtask

   task automatic pulse_start();
      play_start = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      model_cnt = 0;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // k = 0 is the sample right after the edge that took play_start
   task automatic watch(input int budget, input int exp_done_k, input int drop_loop_k);
      int   run, dones;
      logic prev_act;
      logic [1:0] prev_idx;
      exp_t e;
      run = 0; dones = 0; prev_act = 1'b0; prev_idx = '0;
      for (int k = 0; k < budget; k++) begin
         if (k == drop_loop_k) loop_en = 1'b0;
         if (out_active && (!prev_act || play_index != prev_idx)) begin
            if (exp_q.size() == 0) chk("queue_underflow", 32'(exp_q.size()), 1);
            else begin
               e = exp_q.pop_front();
               chk("note",  out_note,   e.note);
               chk("oct",   out_octave, e.oct);
               chk("index", play_index, e.idx);
            end
         end
         if (out_active) run++;
         else begin
            if (prev_act) chk("note_len", run, 4);
            run = 0;
         end
         if (done) begin
            dones++;
            chk("done_time", k, exp_done_k);
            chk("busy_at_done", busy, 0);
         end
         prev_act = out_active; prev_idx = play_index;
         if (done) break;
         @(negedge clk);
      end
      chk("done_count", dones, 1);
      chk("queue_empty", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      bit   found, any_busy, any_done;
      int   run, dones;
      exp_t e;

      rst = 1'b1; rec_valid = 0; clear = 0; play_start = 0; play_stop = 0; loop_en = 0;
      rec_note = '0; rec_octave = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_outputs", {out_note, out_octave, out_active, busy, note_count, play_index, full, done}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy",  busy, 0);
      chk("post_rst_count", note_count, 0);

      // basic record + play, no loop
      rec(4'h1, 2'd0); rec(4'h5, 2'd1); rec(4'hA, 2'd2);
      chk("count3", note_count, 3);
      chk("full3",  full, 0);
      push_play(1);
      pulse_start();
      watch(40, 18, -1);
      chk("idle_after", busy, 0);

      // fill and overflow, empty start
      do_clear();
      chk("clr_count", note_count, 0);
      rec(4'h2, 2'd0); rec(4'h3, 2'd1); rec(4'h4, 2'd2); rec(4'h6, 2'd3);
      chk("full4",  full, 1);
      chk("count4", note_count, 4);
      rec(4'hF, 2'd3);
      chk("count_ovf", note_count, 4);
      chk("full_ovf",  full, 1);
      do_clear();
      chk("full_clr", full, 0);
      pulse_start();
      any_busy = 0; any_done = 0;
      for (int k = 0; k < 6; k++) begin
         any_busy |= busy; any_done |= done;
         @(negedge clk);
      end
      chk("empty_start_busy", any_busy, 0);
      chk("empty_start_done", any_done, 0);

      // looped playback of two notes, loop dropped during final note
      rec(4'h3, 2'd1); rec(4'h7, 2'd3);
      loop_en = 1'b1;
      push_play(2);
      pulse_start();
      watch(40, 24, 20);

      // stop during note at index 1
      do_clear();
      rec(4'h1, 2'd0); rec(4'h5, 2'd1); rec(4'hA, 2'd2);
      pulse_start();
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (out_active && play_index == 2'd1) found = 1;
         else @(negedge clk);
      end
      chk("reach_idx1", found, 1);
      play_stop = 1'b1;
      @(negedge clk);
      play_stop = 1'b0;
      chk("stop_busy",   busy, 0);
      chk("stop_active", out_active, 0);
      chk("stop_index",  play_index, 0);
      chk("stop_count",  note_count, 3);
      chk("stop_done",   done, 0);

      // start and record on the same edge: new note becomes last entry
      do_clear();
      rec(4'h2, 2'd0);
      play_start = 1'b1;
      push_play(1);
      rec(4'h9, 2'd1);
      play_start = 1'b0;
      push_play(1);
      exp_q.pop_front();
      chk("start_rec_count", note_count, 2);
      watch(30, 12, -1);

      // clear with record during the gap
      pulse_start();
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (busy && !out_active) found = 1;
         else @(negedge clk);
      end
      chk("reach_gap", found, 1);
      clear = 1'b1; rec_valid = 1'b1; rec_note = 4'hE; rec_octave = 2'd2;
      model_cnt = 0;
      @(negedge clk);
      clear = 1'b0; rec_valid = 1'b0;
      chk("gapclr_busy",  busy, 0);
      chk("gapclr_count", note_count, 0);
      any_done = 0;
      for (int k = 0; k < 8; k++) begin
         any_done |= done;
         @(negedge clk);
      end
      chk("gapclr_done", any_done, 0);

      // zero-gap instance: back-to-back notes, then async reset mid-note
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_cnt = 0;
      rec(4'h4, 2'd0); rec(4'h8, 2'd1); rec(4'hC, 2'd3);
      chk("g0_count", note_count0, 3);
      push_play(1);
      pulse_start();
      run = 0; dones = 0;
      for (int k = 0; k < 20; k++) begin
         if (k < 12 && (k % 4) == 0) begin
            if (exp_q.size() == 0) chk("g0_queue_underflow", 32'(exp_q.size()), 1);
            else begin
               e = exp_q.pop_front();
               chk("g0_note",  out_note0,   e.note);
               chk("g0_oct",   out_octave0, e.oct);
               chk("g0_index", play_index0, e.idx);
            end
         end
         if (out_active0) run++;
         if (done0) begin
            dones++;
            chk("g0_done_time", k, 12);
            chk("g0_run", run, 12);
            break;
         end
         @(negedge clk);
      end
      chk("g0_done_count", dones, 1);
      exp_q.delete();

      pulse_start();
      @(negedge clk);
      chk("g0_mid_active", out_active0, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst",  {out_note, out_octave, out_active, busy, note_count, play_index, full, done}, 0);
      chk("async_rst0", {out_note0, out_octave0, out_active0, busy0, note_count0, play_index0, full0, done0}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
